microstep_phase_gen: RTL and testbench

- Converts step/dir pulses into per-coil PWM magnitudes and polarities for a two-phase stepper.
- Keeps an 8-bit electrical phase (256 microsteps per electrical cycle) and looks up a quarter-wave sine table.
- Scales the result by a current setting and drives the pwm1/pwm2 inputs of the downstream PWM generator.
- New values are committed only at PWM period boundaries, so a PWM period never glitches mid-cycle.

---
 rtl/microstep_phase_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_microstep_phase_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microstep_phase_gen.sv
// Step/dir to two-phase microstep PWM magnitudes: 8-bit electrical phase, quarter-wave
// sine lookup, current scaling through one shared table port and multiplier.
module microstep_phase_gen #(
    parameter int unsigned PHASE_BITS  = 8,
    parameter int unsigned TABLE_DEPTH = 65
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  dir,
    input  logic [2:0]            step_sel,
    input  logic                  enable,
    input  logic [7:0]            current_scale,
    input  logic                  period_sync,
    output logic [7:0]            pwm1,
    output logic [7:0]            pwm2,
    output logic                  phase_a_neg,
    output logic                  phase_b_neg,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  busy
);

    localparam int unsigned MAG_W   = 8;
    localparam int unsigned SCALE_W = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned IDX_W   = PHASE_BITS - 2;
    localparam int unsigned TAB_AW  = $clog2(TABLE_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOK_A,
        ST_MUL_A,
        ST_LOOK_B,
        ST_MUL_B
    } state_t;

    state_t state, state_next;

    logic                  dirty;
    logic                  enable_q;
    logic                  pending;
    logic [PHASE_BITS-1:0] cap_phase;
    logic [SCALE_W-1:0]    cap_scale;
    logic [MAG_W-1:0]      tab_q;
    logic [MAG_W-1:0]      mul_a_q;
    logic [MAG_W-1:0]      res_a;
    logic [MAG_W-1:0]      res_b;
    logic                  res_a_neg;
    logic                  res_b_neg;

    logic                  start_c;
    logic                  look_a_c;
    logic                  mul_a_c;
    logic                  look_b_c;
    logic                  mul_b_c;

    // Quarter-wave table: round(255*sin(k*pi/128)), k = 0..64
    function automatic logic [MAG_W-1:0] sine_lut(input logic [TAB_AW-1:0] k);
        logic [MAG_W-1:0] v;
        case (k)
            7'd0:  v = 8'd0;    7'd1:  v = 8'd6;    7'd2:  v = 8'd13;   7'd3:  v = 8'd19;
            7'd4:  v = 8'd25;   7'd5:  v = 8'd31;   7'd6:  v = 8'd37;   7'd7:  v = 8'd44;
            7'd8:  v = 8'd50;   7'd9:  v = 8'd56;   7'd10: v = 8'd62;   7'd11: v = 8'd68;
            7'd12: v = 8'd74;   7'd13: v = 8'd80;   7'd14: v = 8'd86;   7'd15: v = 8'd92;
            7'd16: v = 8'd98;   7'd17: v = 8'd103;  7'd18: v = 8'd109;  7'd19: v = 8'd115;
            7'd20: v = 8'd120;  7'd21: v = 8'd126;  7'd22: v = 8'd131;  7'd23: v = 8'd136;
            7'd24: v = 8'd142;  7'd25: v = 8'd147;  7'd26: v = 8'd152;  7'd27: v = 8'd157;
            7'd28: v = 8'd162;  7'd29: v = 8'd167;  7'd30: v = 8'd171;  7'd31: v = 8'd176;
            7'd32: v = 8'd180;  7'd33: v = 8'd185;  7'd34: v = 8'd189;  7'd35: v = 8'd193;
            7'd36: v = 8'd197;  7'd37: v = 8'd201;  7'd38: v = 8'd205;  7'd39: v = 8'd208;
            7'd40: v = 8'd212;  7'd41: v = 8'd215;  7'd42: v = 8'd219;  7'd43: v = 8'd222;
            7'd44: v = 8'd225;  7'd45: v = 8'd228;  7'd46: v = 8'd231;  7'd47: v = 8'd233;
            7'd48: v = 8'd236;  7'd49: v = 8'd238;  7'd50: v = 8'd240;  7'd51: v = 8'd242;
            7'd52: v = 8'd244;  7'd53: v = 8'd246;  7'd54: v = 8'd247;  7'd55: v = 8'd249;
            7'd56: v = 8'd250;  7'd57: v = 8'd251;  7'd58: v = 8'd252;  7'd59: v = 8'd253;
            7'd60: v = 8'd254;  7'd61: v = 8'd254;  7'd62: v = 8'd255;  7'd63: v = 8'd255;
            7'd64: v = 8'd255;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Step increment: 1 << (6 - step_sel), with 7 clamped to 6
    logic [2:0]            sel_eff;
    logic [PHASE_BITS-1:0] step_inc;
    logic                  step_ok;
    logic                  enable_rise;

    assign sel_eff     = (step_sel == 3'd7) ? 3'd6 : step_sel;
    assign step_inc    = PHASE_BITS'(1) << (3'd6 - sel_eff);
    assign step_ok     = step & enable;
    assign enable_rise = enable & ~enable_q;

    // Quadrant decode of the captured phase; odd quadrants mirror the table
    logic [1:0]        quad;
    logic [IDX_W-1:0]  idx;
    logic [TAB_AW-1:0] idx_ext;
    logic [TAB_AW-1:0] idx_mir;
    logic [TAB_AW-1:0] addr_a;
    logic [TAB_AW-1:0] addr_b;
    logic [TAB_AW-1:0] tab_addr;
    logic [MAG_W-1:0]  tab_data;

    assign quad     = cap_phase[PHASE_BITS-1 -: 2];
    assign idx      = cap_phase[IDX_W-1:0];
    assign idx_ext  = {1'b0, idx};
    assign idx_mir  = TAB_AW'(TABLE_DEPTH - 1) - idx_ext;
    assign addr_a   = quad[0] ? idx_mir : idx_ext;
    assign addr_b   = quad[0] ? idx_ext : idx_mir;
    assign tab_addr = look_b_c ? addr_b : addr_a;
    assign tab_data = sine_lut(tab_addr);

    // Shared multiplier: (mag * (scale + 1)) >> 8; max 255*256 fits in 16 bits
    logic [SCALE_W:0]   scale_p1;
    logic [PROD_W-1:0]  prod;
    logic [MAG_W-1:0]   scaled;

    assign scale_p1 = {1'b0, cap_scale} + (SCALE_W + 1)'(1);
    assign prod     = PROD_W'(tab_q) * PROD_W'(scale_p1);
    assign scaled   = MAG_W'(prod >> 8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        look_a_c   = 1'b0;
        mul_a_c    = 1'b0;
        look_b_c   = 1'b0;
        mul_b_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dirty) begin
                    start_c    = 1'b1;
                    state_next = ST_LOOK_A;
                end
            end
            ST_LOOK_A: begin
                look_a_c   = 1'b1;
                state_next = ST_MUL_A;
            end
            ST_MUL_A: begin
                mul_a_c    = 1'b1;
                state_next = ST_LOOK_B;
            end
            ST_LOOK_B: begin
                look_b_c   = 1'b1;
                state_next = ST_MUL_B;
            end
            ST_MUL_B: begin
                mul_b_c    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Phase accumulator and recompute request; a new step wins over the IDLE clear
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            dirty    <= 1'b1;
            enable_q <= 1'b1;
            busy     <= 1'b0;
        end else begin
            enable_q <= enable;
            busy     <= (state_next != ST_IDLE);
            if (step_ok) begin
                phase <= dir ? (phase + step_inc) : (phase - step_inc);
            end
            if (step_ok || enable_rise) begin
                dirty <= 1'b1;
            end else if (start_c) begin
                dirty <= 1'b0;
            end
        end
    end

    // Compute datapath; A and B results publish together so a commit never mixes computes
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_phase <= '0;
            cap_scale <= '0;
            tab_q     <= '0;
            mul_a_q   <= '0;
            res_a     <= '0;
            res_b     <= '0;
            res_a_neg <= 1'b0;
            res_b_neg <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (start_c) begin
                cap_phase <= phase;
                cap_scale <= current_scale;
            end
            if (look_a_c || look_b_c) begin
                tab_q <= tab_data;
            end
            if (mul_a_c) begin
                mul_a_q <= scaled;
            end
            if (mul_b_c) begin
                res_a     <= mul_a_q;
                res_b     <= scaled;
                res_a_neg <= quad[1];
                res_b_neg <= quad[1] ^ quad[0];
            end
            if (!enable) begin
                pending <= 1'b0;
            end else if (mul_b_c) begin
                pending <= 1'b1;
            end else if (period_sync) begin
                pending <= 1'b0;
            end
        end
    end

    // Output commit at PWM period start; disable forces zero magnitude immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm1        <= '0;
            pwm2        <= '0;
            phase_a_neg <= 1'b0;
            phase_b_neg <= 1'b0;
        end else if (!enable) begin
            pwm1 <= '0;
            pwm2 <= '0;
        end else if (period_sync && pending) begin
            pwm1        <= res_a;
            pwm2        <= res_b;
            phase_a_neg <= res_a_neg;
            phase_b_neg <= res_b_neg;
        end
    end

endmodule

// File: tb/tb_microstep_phase_gen.sv
// Self-checking bench for microstep_phase_gen: hand vectors, corner sequences and
// randomized steps against a trigonometric reference model.
module tb_microstep_phase_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       step;
    logic       dir;
    logic [2:0] step_sel;
    logic       enable;
    logic [7:0] current_scale;
    logic       period_sync;
    logic [7:0] pwm1;
    logic [7:0] pwm2;
    logic       phase_a_neg;
    logic       phase_b_neg;
    logic [7:0] phase;
    logic       busy;

    microstep_phase_gen dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .dir          (dir),
        .step_sel     (step_sel),
        .enable       (enable),
        .current_scale(current_scale),
        .period_sync  (period_sync),
        .pwm1         (pwm1),
        .pwm2         (pwm2),
        .phase_a_neg  (phase_a_neg),
        .phase_b_neg  (phase_b_neg),
        .phase        (phase),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: electrical phase and the values expected on the committed outputs
    int m_phase = 0;
    int m_p1 = 0;
    int m_p2 = 0;
    int m_an = 0;
    int m_bn = 0;

    typedef struct {
        int d;
        int sel;
        int sc;
        int n;
        int ph;
        int p1;
        int p2;
        int an;
        int bn;
    } vec_t;

    vec_t vt[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Coil A follows |sin|, coil B follows |cos| of the electrical angle
    function automatic int ref_mag(input int ph, input int coil_b);
        real th;
        real s;
        th = real'(ph) * 3.14159265358979 / 128.0;
        s  = (coil_b != 0) ? $cos(th) : $sin(th);
        if (s < 0.0) s = -s;
        return $rtoi(s * 255.0 + 0.5);
    endfunction

    function automatic int ref_pwm(input int ph, input int sc, input int coil_b);
        return (ref_mag(ph, coil_b) * (sc + 1)) / 256;
    endfunction

    task automatic do_step(input int d, input int sel);
        int inc;
        inc      = 1 << (6 - ((sel > 6) ? 6 : sel));
        dir      = (d != 0);
        step_sel = 3'(sel);
        step     = 1'b1;
        tick();
        step     = 1'b0;
        m_phase  = (m_phase + 256 + ((d != 0) ? inc : -inc)) % 256;
    endtask

    // Wait until the sequencer has stayed idle for three consecutive samples
    task automatic settle(input string name);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < 200) begin
            tick();
            n++;
            if (busy) quiet = 0;
            else quiet++;
        end
        checks++;
        if (quiet < 3) begin
            errors++;
            $display("FAIL %s_settle: busy still %0d after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic commit_sync(input int sc);
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        m_p1 = ref_pwm(m_phase, sc, 0);
        m_p2 = ref_pwm(m_phase, sc, 1);
        m_an = (m_phase >= 128) ? 1 : 0;
        m_bn = (m_phase >= 64 && m_phase < 192) ? 1 : 0;
    endtask

    task automatic check_outs(input string name);
        check({name, ".pwm1"}, int'(pwm1), m_p1);
        check({name, ".pwm2"}, int'(pwm2), m_p2);
        check({name, ".a_neg"}, int'(phase_a_neg), m_an);
        check({name, ".b_neg"}, int'(phase_b_neg), m_bn);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int n;

        vt[0] = '{1, 1, 255, 1,  32, 180, 180, 0, 0};
        vt[1] = '{0, 1, 255, 1,   0,   0, 255, 0, 0};
        vt[2] = '{0, 0, 255, 1, 192, 255,   0, 1, 0};
        vt[3] = '{1, 0, 127, 2,  64, 127,   0, 0, 1};
        vt[4] = '{1, 0,   0, 1, 128,   0,   0, 1, 1};
        vt[5] = '{1, 7, 255, 3, 131,  19, 254, 1, 1};
        vt[6] = '{0, 2, 200, 1, 115,  62, 190, 0, 1};
        vt[7] = '{1, 4,  63, 1, 119,  14,  62, 0, 1};
        vt[8] = '{0, 5, 255, 60, 255,  6, 255, 1, 0};
        vt[9] = '{1, 6, 255, 1,   0,   0, 255, 0, 0};

        reset         = 1'b1;
        step          = 1'b0;
        dir           = 1'b0;
        step_sel      = 3'd0;
        enable        = 1'b1;
        current_scale = 8'd255;
        period_sync   = 1'b0;
        tick();
        tick();
        check("rst.phase", int'(phase), 0);
        check("rst.pwm1", int'(pwm1), 0);
        check("rst.pwm2", int'(pwm2), 0);
        check("rst.a_neg", int'(phase_a_neg), 0);
        check("rst.b_neg", int'(phase_b_neg), 0);
        check("rst.busy", int'(busy), 0);

        // Initial compute after reset, held until the first period_sync
        reset = 1'b0;
        settle("init");
        check("init.hold_pwm2", int'(pwm2), 0);
        commit_sync(255);
        check("init.pwm1", int'(pwm1), 0);
        check("init.pwm2", int'(pwm2), 255);
        check("init.a_neg", int'(phase_a_neg), 0);
        check("init.b_neg", int'(phase_b_neg), 0);

        for (int i = 0; i < 10; i++) begin
            current_scale = 8'(vt[i].sc);
            for (int s = 0; s < vt[i].n; s++) begin
                do_step(vt[i].d, vt[i].sel);
            end
            settle($sformatf("vec%0d", i));
            check($sformatf("vec%0d.phase", i), int'(phase), vt[i].ph);
            commit_sync(vt[i].sc);
            check($sformatf("vec%0d.pwm1", i), int'(pwm1), vt[i].p1);
            check($sformatf("vec%0d.pwm2", i), int'(pwm2), vt[i].p2);
            check($sformatf("vec%0d.a_neg", i), int'(phase_a_neg), vt[i].an);
            check($sformatf("vec%0d.b_neg", i), int'(phase_b_neg), vt[i].bn);
        end

        // Compute latency with period_sync held high: commit lands one cycle after MUL_B
        current_scale = 8'd255;
        period_sync   = 1'b1;
        do_step(1, 3);
        tick();
        check("lat.busy_e1", int'(busy), 1);
        repeat (4) tick();
        check("lat.busy_e5", int'(busy), 0);
        check("lat.hold_pwm1", int'(pwm1), m_p1);
        check("lat.hold_pwm2", int'(pwm2), m_p2);
        tick();
        period_sync = 1'b0;
        m_p1 = ref_pwm(m_phase, 255, 0);
        m_p2 = ref_pwm(m_phase, 255, 1);
        m_an = (m_phase >= 128) ? 1 : 0;
        m_bn = (m_phase >= 64 && m_phase < 192) ? 1 : 0;
        check_outs("lat");

        // Second step lands while the first compute is running
        do_step(1, 6);
        tick();
        do_step(1, 6);
        check("busy_step.busy", int'(busy), 1);
        settle("busy_step");
        check("busy_step.phase", int'(phase), m_phase);
        check("busy_step.hold_pwm1", int'(pwm1), m_p1);
        check("busy_step.hold_pwm2", int'(pwm2), m_p2);
        commit_sync(255);
        check_outs("busy_step");

        // Scale change alone must not trigger a compute or a commit
        current_scale = 8'd50;
        repeat (10) tick();
        check("scale_only.busy", int'(busy), 0);
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        check("scale_only.pwm1", int'(pwm1), m_p1);
        check("scale_only.pwm2", int'(pwm2), m_p2);
        do_step(0, 6);
        settle("scale_new");
        commit_sync(50);
        check_outs("scale_new");

        // Disable forces zero magnitude at once; re-enable recomputes the same phase
        current_scale = 8'd255;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_phase = 0;
        settle("dis_rst");
        commit_sync(255);
        do_step(1, 1);
        settle("dis_pre");
        commit_sync(255);
        check("dis_pre.pwm1", int'(pwm1), 180);
        enable = 1'b0;
        tick();
        check("dis.pwm1", int'(pwm1), 0);
        check("dis.pwm2", int'(pwm2), 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("dis.step_ignored", int'(phase), 32);
        enable = 1'b1;
        settle("reen");
        check("reen.hold_pwm1", int'(pwm1), 0);
        commit_sync(255);
        check("reen.pwm1", int'(pwm1), 180);
        check("reen.pwm2", int'(pwm2), 180);

        // Reset in the middle of a compute
        do_step(1, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid.busy", int'(busy), 0);
        check("rst_mid.phase", int'(phase), 0);
        check("rst_mid.pwm1", int'(pwm1), 0);
        check("rst_mid.pwm2", int'(pwm2), 0);
        reset = 1'b0;
        m_phase = 0;
        settle("rst_mid");
        commit_sync(255);
        check_outs("rst_mid");

        // Randomized steps, gaps and scales against the reference model
        for (int it = 0; it < 40; it++) begin
            sc = int'($urandom_range(0, 255));
            current_scale = 8'(sc);
            n = int'($urandom_range(1, 3));
            for (int s = 0; s < n; s++) begin
                do_step(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 3)) tick();
            end
            settle($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d.phase", it), int'(phase), m_phase);
            check($sformatf("rnd%0d.hold_pwm1", it), int'(pwm1), m_p1);
            commit_sync(sc);
            check_outs($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
